// File: rtl/fp_normalizer.sv
// Post-add normalizer: raw {sign, exp, 25b mantissa} in, packed IEEE-754 single and {N,Z,V,U} flags out.
// Latency: 1 cycle, plus one cycle per left shift (at most 23), or until the exponent bottoms out and the result flushes.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready is seen.
module fp_normalizer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MAN_W+1:0]     in_man,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [3:0]           out_flags,
    output logic                 busy
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   sign_r, sign_nxt;
    logic [EXP_W-1:0]       exp_r, exp_nxt;
    logic [MAN_W+1:0]       man_r, man_nxt;
    logic [EXP_W+MAN_W:0]   result_r, result_nxt;
    logic [3:0]             flags_r, flags_nxt;

    logic                   fin;
    logic                   ovf;
    logic                   unf;
    logic [EXP_W+MAN_W:0]   res;
    logic [EXP_W-1:0]       exp_inc;
    logic [EXP_W-1:0]       exp_dec;

    assign exp_inc = in_exp + EXP_ONE;
    assign exp_dec = exp_r - EXP_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            man_r    <= '0;
            result_r <= '0;
            flags_r  <= '0;
        end else begin
            state    <= state_nxt;
            sign_r   <= sign_nxt;
            exp_r    <= exp_nxt;
            man_r    <= man_nxt;
            result_r <= result_nxt;
            flags_r  <= flags_nxt;
        end
    end

    // Classification runs on the capture edge; SHIFT only sees operands that genuinely need left shifts.
    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_r;
        exp_nxt   = exp_r;
        man_nxt   = man_r;
        fin       = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        res       = '0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt = in_sign;
                    exp_nxt  = in_exp;
                    man_nxt  = in_man;
                    if (in_man == '0) begin
                        fin = 1'b1;
                    end else if (in_exp == EXP_MAX) begin
                        res = {in_sign, EXP_MAX, {MAN_W{1'b0}}};
                        ovf = 1'b1;
                        fin = 1'b1;
                    end else if (in_man[MAN_W+1]) begin
                        exp_nxt = exp_inc;
                        man_nxt = in_man >> 1;
                        fin     = 1'b1;
                        if (exp_inc == EXP_MAX) begin
                            res = {in_sign, EXP_MAX, {MAN_W{1'b0}}};
                            ovf = 1'b1;
                        end else begin
                            res = {in_sign, exp_inc, in_man[MAN_W:1]};
                        end
                    end else if (in_man[MAN_W] && in_exp != '0) begin
                        res = {in_sign, in_exp, in_man[MAN_W-1:0]};
                        fin = 1'b1;
                    end else if (in_exp == '0) begin
                        unf = 1'b1;
                        fin = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (exp_r == EXP_ONE) begin
                    unf = 1'b1;
                    fin = 1'b1;
                end else begin
                    man_nxt = man_r << 1;
                    exp_nxt = exp_dec;
                    if (man_r[MAN_W-1]) begin
                        res = {sign_r, exp_dec, man_r[MAN_W-2:0], 1'b0};
                        fin = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (fin) begin
            state_nxt = DONE;
        end
    end

    // Result and flags load only on the DONE-entry edge; flushes and zeros are always +0.
    always_comb begin
        result_nxt = result_r;
        flags_nxt  = flags_r;
        if (fin) begin
            result_nxt = res;
            flags_nxt  = {res[EXP_W+MAN_W], ~|res[EXP_W+MAN_W-1:0], ovf, unf};
        end
    end

    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        out_result = result_r;
        out_flags  = flags_r;
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized and directed bench for fp_normalizer against a leading-one/exponent arithmetic model.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    fp_normalizer #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    // Reference: locate the leading one, then derive the exponent change and shift count arithmetically.
    task automatic model(input logic sg, input logic [7:0] ex, input logic [24:0] mn,
                         output logic [31:0] r, output logic [3:0] f, output int k);
        int p;
        int e;
        int s;
        logic [31:0] ev;
        logic [24:0] m;
        logic v;
        logic u;
        r = 32'h0; v = 1'b0; u = 1'b0; k = 0; p = -1;
        for (int i = 0; i < 25; i++) if (mn[i]) p = i;
        if (mn == 25'h0) begin
            r = 32'h0;
        end else if (ex == 8'hFF) begin
            r = {sg, 8'hFF, 23'h0}; v = 1'b1;
        end else if (p == 24) begin
            e = int'(ex) + 1;
            if (e >= 255) begin
                r = {sg, 8'hFF, 23'h0}; v = 1'b1;
            end else begin
                ev = e;
                r = {sg, ev[7:0], mn[23:1]};
            end
        end else if (ex == 8'h00) begin
            u = 1'b1;
        end else begin
            s = 23 - p;
            if (int'(ex) > s) begin
                k = s;
                ev = int'(ex) - s;
                m = mn << s;
                r = {sg, ev[7:0], m[22:0]};
            end else begin
                k = int'(ex);
                u = 1'b1;
            end
        end
        f = {r[31], (r[30:0] == 31'h0), v, u};
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [7:0] ex, input logic [24:0] mn,
                          input logic [31:0] want_r, input logic [3:0] want_f, input int want_k,
                          input int hold);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        check({tag, "_rdy"}, {31'h0, in_ready}, 32'h1);
        in_sign = sg; in_exp = ex; in_man = mn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 60) begin
            @(posedge clk); #1; cnt++;
        end
        check({tag, "_lat"}, cnt, want_k);
        check({tag, "_res"}, out_result, want_r);
        check({tag, "_flg"}, {28'h0, out_flags}, {28'h0, want_f});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, out_result, want_r);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {29'h0, in_ready, out_valid, busy}, 32'h4);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          k;
        int          p;
        logic [24:0] mask;
        logic [24:0] m;
        logic [7:0]  e;
        logic        sg;

        reset = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0; in_man = 25'h0; out_ready = 1'b0;
        #2;
        check("rst_ctl", {29'h0, in_ready, out_valid, busy}, 32'h4);
        check("rst_res", out_result, 32'h0);
        check("rst_flg", {28'h0, out_flags}, 32'h0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        run_op("pass",  1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 4'b0000, 0, 2);
        run_op("carry", 1'b0, 8'h7F, 25'h1800000, 32'h40400000, 4'b0000, 0, 0);
        run_op("ovf",   1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 4'b0010, 0, 0);
        run_op("canc",  1'b1, 8'h82, 25'h0000400, 32'hBA800000, 4'b1000, 13, 1);
        run_op("zero",  1'b1, 8'h40, 25'h0000000, 32'h00000000, 4'b0100, 0, 0);
        run_op("unf",   1'b0, 8'h03, 25'h0000100, 32'h00000000, 4'b0101, 3, 0);
        run_op("inf",   1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 4'b1010, 0, 0);
        run_op("den",   1'b1, 8'h00, 25'h0800000, 32'h00000000, 4'b0101, 0, 0);
        run_op("max23", 1'b0, 8'h20, 25'h0000001, 32'h04800000, 4'b0000, 23, 0);
        run_op("e1",    1'b0, 8'h01, 25'h0400000, 32'h00000000, 4'b0101, 1, 0);

        // Backpressure: a second operand presented during DONE must wait for the handoff.
        in_sign = 1'b0; in_exp = 8'h7F; in_man = 25'h0C00000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_exp = 8'h7F; in_man = 25'h1800000;
        check("bp_vld", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_res", out_result, 32'h3FC00000);
            check("bp_ctl", {30'h0, in_ready, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_hand", {29'h0, in_ready, out_valid, busy}, 32'h4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_2vld", {31'h0, out_valid}, 32'h1);
        check("bp_2res", out_result, 32'h40400000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of the cancellation shifts.
        in_sign = 1'b1; in_exp = 8'h82; in_man = 25'h0000400; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_ctl", {29'h0, in_ready, out_valid, busy}, 32'h4);
        check("mid_res", out_result, 32'h0);
        #8 reset = 1'b1;
        @(posedge clk); #1;
        run_op("post", 1'b1, 8'h82, 25'h0000400, 32'hBA800000, 4'b1000, 13, 0);

        for (int n = 0; n < 250; n++) begin
            sg = 1'($urandom());
            case ($urandom_range(0, 5))
                0:       e = 8'h00;
                1:       e = 8'($urandom_range(1, 6));
                2:       e = 8'hFE;
                3:       e = 8'hFF;
                default: e = 8'($urandom());
            endcase
            p = $urandom_range(0, 25);
            if (p == 25) begin
                m = 25'h0;
            end else begin
                mask = (25'h1 << p) - 25'h1;
                m = (25'($urandom()) & mask) | (25'h1 << p);
            end
            model(sg, e, m, r, f, k);
            run_op("rnd", sg, e, m, r, f, k, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Multi-cycle post-normalization stage that sits directly downstream of the ALU's floating-point add path. It accepts the raw sum as sign, 8-bit biased exponent and 25-bit mantissa, which may carry out into bit 24 or have leading zeros after cancellation. It normalizes the mantissa one bit per cycle and emits a packed IEEE-754 single plus status flags. Rounding is truncation; denormals flush to zero.

## Interface
- EXP_W, 8, exponent width; fixed, not generic-tested
- MAN_W, 23, stored fraction width; raw mantissa input is MAN_W+2 bits
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  raw operand valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_sign  in  1  raw sign
- in_exp  in  8  raw biased exponent, unsigned
- in_man  in  25  bit24 = carry, bit23 = hidden one, bits 22:0 = fraction
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- out_result  out  32  {sign, exp[7:0], frac[22:0]}
- out_flags  out  4  {N, Z, V, U}: negative, zero, overflow→inf, underflow→flushed
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE. Registers: sign_r, exp_r (8b), man_r (25b), result, flags.
- IDLE, in_valid=1: capture the operand and classify it in the same edge, in priority order:
  - in_man==0 → result 0x00000000, Z=1 → DONE
  - in_exp==255 → {in_sign, 8'hFF, 23'b0}, V=1 → DONE
  - in_man[24]=1 → mantissa >>1 (drop LSB), exp+1; if the new exp==255 → infinity, V=1; else pack → DONE
  - in_man[23]=1 and in_exp!=0 → pack as is → DONE
  - in_exp==0 (nonzero mantissa) → flush 0x00000000, Z=1, U=1 → DONE
  - otherwise → SHIFT
- SHIFT, each cycle:
  - if exp_r==1 → flush 0x00000000, Z=1, U=1 → DONE
  - else man_r<<=1, exp_r-=1; if the shifted man_r[23]=1 → pack → DONE
- Maximum shift count is 23 (in_man=1).
- DONE: out_valid=1. out_result and out_flags are held stable until out_ready=1, then go to IDLE. No accept in the same cycle as the handoff.
- Pack = {sign_r, exp_r, man_r[22:0]}.
- Flags: N=out_result[31], Z=(out_result[30:0]==0). Zero results are always +0, so N=0 on any flush or zero.
- in_valid while not IDLE is ignored. Upstream holds its data until in_ready.
- All exponent arithmetic is unsigned 8-bit. Overflow and underflow are detected explicitly, never by wrap-around.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, out_valid=0, out_result=0, out_flags=0, busy=0, in_ready=1. Takes effect immediately, including mid-SHIFT or mid-DONE; the in-flight operation is discarded.
- Capture edge E0:
  - no shift needed: DONE from E0, out_valid high the cycle after E0
  - k shifts needed: DONE entered at edge Ek, out_valid high after Ek
  - flush in SHIFT: occurs at the edge where exp_r==1 is seen
- Handoff: out_valid·out_ready at edge Eh → IDLE after Eh. Earliest next capture is at Eh+1. Minimum initiation interval is k+2 cycles.
- out_result and out_flags are registered and change only on the DONE-entry edge or on reset.
- in_ready and busy decode directly from state, with no combinational path from in_valid or out_ready.

## Test plan
- Normalized pass-through: sign0, exp 0x7F, man 0x0C00000 → out_result 0x3FC00000, flags 0000, out_valid the cycle after capture.
- Carry renormalize: sign0, exp 0x7F, man 0x1800000 → 0x40400000, flags 0000. Overflow variant: exp 0xFE, man 0x1000000 → 0x7F800000, V=1.
- Cancellation: sign1, exp 0x82, man 0x0000400 → 13 SHIFT cycles, out_valid after edge E13, out_result 0xBA800000, N=1.
- Zero and underflow:
  - man 0 → 0x00000000, Z=1, one-cycle latency
  - exp 0x03, man 0x0000100 → two shifts, then flush at E3 → 0x00000000, Z=1, U=1
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_result stable, in_ready=0, a second in_valid is ignored; out_ready=1 → IDLE next cycle, second operand captured one cycle later.
- Reset mid-op: drive reset=0 during the 5th SHIFT cycle of the cancellation case → out_valid=0, busy=0, in_ready=1 immediately, with no clock edge required; after release a fresh operand completes normally.
